// File: rtl/axis_dest_classifier.sv
// Stamps a per-frame tdest taken from the first beat and drops unroutable frames.
// The output uses a registered skid stage, so both tready and tvalid are registered.
module axis_dest_classifier #(
    parameter int DATA_WIDTH     = 64,
    parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH     = (DATA_WIDTH / 8),
    parameter int ID_ENABLE      = 1,
    parameter int ID_WIDTH       = 8,
    parameter int DEST_WIDTH     = 3,
    parameter int DEST_OFFSET    = 0,
    parameter int MAX_DEST       = 3,
    parameter int USER_ENABLE    = 1,
    parameter int USER_WIDTH     = 1,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [ID_WIDTH-1:0]       s_axis_tid,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [ID_WIDTH-1:0]       m_axis_tid,
    output logic [DEST_WIDTH-1:0]     m_axis_tdest,
    output logic [USER_WIDTH-1:0]     m_axis_tuser,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output logic                      drop_pulse
);

    localparam int unsigned MAX_U = MAX_DEST;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        DROP
    } state_t;

    state_t state, state_next;

    logic [DEST_WIDTH-1:0]     dest_reg, dest_next, fwd_dest, field;
    logic                      accept, fwd, drop_start, field_bad;
    beat_t                     in_beat, out_reg, temp_reg;
    logic                      out_valid, out_valid_next;
    logic                      temp_valid, temp_valid_next;
    logic                      ready_reg, ready_next;
    logic                      load_out, load_temp, temp_to_out;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_reg;
    logic                      drop_pulse_reg;

    assign field     = s_axis_tdata[DEST_OFFSET +: DEST_WIDTH];
    assign field_bad = 32'(field) > MAX_U;
    assign accept    = s_axis_tvalid && ready_reg;

    always_comb begin
        state_next = state;
        dest_next  = dest_reg;
        fwd_dest   = dest_reg;
        fwd        = 1'b0;
        drop_start = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (field_bad) begin
                        drop_start = 1'b1;
                        if (!s_axis_tlast) state_next = DROP;
                    end else begin
                        fwd       = 1'b1;
                        fwd_dest  = field;
                        dest_next = field;
                        if (!s_axis_tlast) state_next = FRAME;
                    end
                end
            end
            FRAME: begin
                if (accept) begin
                    fwd = 1'b1;
                    if (s_axis_tlast) state_next = IDLE;
                end
            end
            DROP: begin
                if (accept && s_axis_tlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_beat.data = s_axis_tdata;
        in_beat.keep = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
        in_beat.last = s_axis_tlast;
        in_beat.id   = (ID_ENABLE != 0) ? s_axis_tid : '0;
        in_beat.dest = fwd_dest;
        in_beat.user = (USER_ENABLE != 0) ? s_axis_tuser : '0;
    end

    // Ready is computed from registered state only; m_axis_tready feeds the flop.
    always_comb begin
        out_valid_next  = out_valid;
        temp_valid_next = temp_valid;
        load_out        = 1'b0;
        load_temp       = 1'b0;
        temp_to_out     = 1'b0;
        ready_next      = m_axis_tready ||
                          (!temp_valid && (!out_valid || !fwd));
        if (ready_reg) begin
            if (m_axis_tready || !out_valid) begin
                out_valid_next = fwd;
                load_out       = 1'b1;
            end else begin
                temp_valid_next = fwd;
                load_temp       = 1'b1;
            end
        end else if (m_axis_tready) begin
            out_valid_next  = temp_valid;
            temp_valid_next = 1'b0;
            temp_to_out     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ready_reg      <= 1'b0;
            out_valid      <= 1'b0;
            temp_valid     <= 1'b0;
            drop_cnt_reg   <= '0;
            drop_pulse_reg <= 1'b0;
        end else begin
            state          <= state_next;
            ready_reg      <= ready_next;
            out_valid      <= out_valid_next;
            temp_valid     <= temp_valid_next;
            drop_pulse_reg <= drop_start;
            if (drop_start && (drop_cnt_reg != {DROP_CNT_WIDTH{1'b1}}))
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        dest_reg <= dest_next;
        if (load_out)
            out_reg <= in_beat;
        else if (temp_to_out)
            out_reg <= temp_reg;
        if (load_temp)
            temp_reg <= in_beat;
    end

    assign s_axis_tready = ready_reg;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_reg.data;
    assign m_axis_tkeep  = out_reg.keep;
    assign m_axis_tlast  = out_reg.last;
    assign m_axis_tid    = out_reg.id;
    assign m_axis_tdest  = out_reg.dest;
    assign m_axis_tuser  = out_reg.user;
    assign drop_count    = drop_cnt_reg;
    assign drop_pulse    = drop_pulse_reg;

endmodule
